wb_core_bus_arbiter: RTL

Round-robin arbiter that shares the single external Wishbone master port among `NUM_CORES` Theia execution cores. Each core's IO unit raises its bus cycle request and waits for its grant line before driving the bus. The block also:
- steers the slave's ACK back to the owning core only;
- revokes a grant whose transfer stalls past a watchdog limit.

It sits at the GPU top level, between the per-core IO units and the shared bus.

---
 rtl/wb_core_bus_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/wb_core_bus_arbiter.sv
// rtl/wb_core_bus_arbiter.sv - round-robin Wishbone master-port arbiter with ACK steering and stall watchdog
module wb_core_bus_arbiter #(
    parameter int NUM_CORES     = 4,
    parameter int IDX_WIDTH     = 2,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NUM_CORES-1:0] iCYC,
    input  logic [NUM_CORES-1:0] iSTB,
    input  logic                 ACK_I,
    output logic [NUM_CORES-1:0] oGNT,
    output logic [NUM_CORES-1:0] oACK,
    output logic [IDX_WIDTH-1:0] oOwner,
    output logic                 oBusy,
    output logic                 oTimeout,
    output logic [IDX_WIDTH-1:0] oTimeoutCore
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLDOFF
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX = {TIMEOUT_WIDTH{1'b1}};
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_PRE = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

    state_t                 state;
    state_t                 stateNext;
    logic [NUM_CORES-1:0]   mask;
    logic [IDX_WIDTH-1:0]   lastOwner;
    logic [TIMEOUT_WIDTH-1:0] wdCount;

    logic [NUM_CORES-1:0]   eligible;
    logic                   pickFound;
    logic [IDX_WIDTH-1:0]   pickIdx;
    logic [NUM_CORES-1:0]   pickOneHot;
    logic                   ownerCyc;
    logic                   ownerStb;
    logic                   expire;

    // Scan upward from the core after the last owner, wrapping at NUM_CORES.
    always_comb begin
        int                   sum;
        logic [IDX_WIDTH-1:0] cand;
        eligible   = iCYC & ~mask;
        pickFound  = 1'b0;
        pickIdx    = lastOwner;
        sum        = 0;
        cand       = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            sum = int'(lastOwner) + k;
            if (sum >= NUM_CORES) begin
                sum = sum - NUM_CORES;
            end
            cand = IDX_WIDTH'(sum);
            if (!pickFound && eligible[cand]) begin
                pickFound = 1'b1;
                pickIdx   = cand;
            end
        end
        pickOneHot          = '0;
        pickOneHot[pickIdx] = 1'b1;
    end

    // Expiry fires on the increment that would land on all-ones, so an ACK that cycle wins.
    always_comb begin
        ownerCyc  = iCYC[oOwner];
        ownerStb  = iSTB[oOwner];
        expire    = (state == GRANT) && ownerStb && !ACK_I && (wdCount == CNT_PRE);
        stateNext = state;
        case (state)
            IDLE:    if (pickFound) stateNext = GRANT;
            GRANT:   if (expire || !ownerCyc) stateNext = HOLDOFF;
            HOLDOFF: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            oGNT         <= '0;
            oOwner       <= '0;
            oTimeout     <= 1'b0;
            oTimeoutCore <= '0;
            mask         <= '0;
            wdCount      <= '0;
            lastOwner    <= IDX_WIDTH'(NUM_CORES - 1);
        end else begin
            state    <= stateNext;
            oTimeout <= 1'b0;
            mask     <= mask & iCYC;
            case (state)
                IDLE: begin
                    wdCount <= '0;
                    if (pickFound) begin
                        oGNT   <= pickOneHot;
                        oOwner <= pickIdx;
                    end
                end
                GRANT: begin
                    if (expire) begin
                        oGNT         <= '0;
                        oTimeout     <= 1'b1;
                        oTimeoutCore <= oOwner;
                        mask[oOwner] <= 1'b1;
                        lastOwner    <= oOwner;
                    end else if (!ownerCyc) begin
                        oGNT      <= '0;
                        lastOwner <= oOwner;
                    end else if (ACK_I) begin
                        wdCount <= '0;
                    end else if (ownerStb && wdCount != CNT_MAX) begin
                        wdCount <= wdCount + 1'b1;
                    end
                end
                default: wdCount <= '0;
            endcase
        end
    end

    assign oACK  = oGNT & {NUM_CORES{ACK_I}};
    assign oBusy = |oGNT;

endmodule
